// File: rtl/seg_scan_if.sv
// Bundle between the seven-segment scan controller and its surroundings:
// the snapshot inputs plus the digit-select and cathode outputs.
interface seg_scan_if;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic [7:0]  blank_in;
  logic        lz_blank;
  logic [2:0]  sel;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  modport master (
    output data_in, dp_in, blank_in, lz_blank,
    input  sel, seg, dp, frame_start
  );

  modport slave (
    input  data_in, dp_in, blank_in, lz_blank,
    output sel, seg, dp, frame_start
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: walks sel across DIGITS slots and
// drives active-low cathodes from a per-frame snapshot of the display inputs.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 12500,
  parameter int DEAD_CYCLES = 500,
  parameter int DIGITS      = 8
) (
  input  logic       clk,
  input  logic       reset,
  seg_scan_if.slave  bus
);

  localparam int              PW         = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0]   DEAD_LIM   = PW'(DEAD_CYCLES);
  localparam logic [2:0]      SEL_LAST   = 3'(DIGITS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    sel_q, sel_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_start_q, frame_start_d;
  logic          load_pending_q, load_pending_d;
  logic [31:0]   sh_data_q, sh_data_d;
  logic [7:0]    sh_dp_q, sh_dp_d;
  logic [7:0]    sh_blank_q, sh_blank_d;
  logic          sh_lz_q, sh_lz_d;

  logic          tick, wrap, load;
  logic [7:0]    lead_zero;
  logic          higher_ok;
  logic [3:0]    nib;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q        <= '0;
      sel_q          <= '0;
      seg_q          <= 7'h7F;
      dp_q           <= 1'b1;
      frame_start_q  <= 1'b0;
      load_pending_q <= 1'b1;
      sh_data_q      <= '0;
      sh_dp_q        <= '0;
      sh_blank_q     <= 8'hFF;
      sh_lz_q        <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      sel_q          <= sel_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
      frame_start_q  <= frame_start_d;
      load_pending_q <= load_pending_d;
      sh_data_q      <= sh_data_d;
      sh_dp_q        <= sh_dp_d;
      sh_blank_q     <= sh_blank_d;
      sh_lz_q        <= sh_lz_d;
    end
  end

  // Slot timing and frame snapshot; the first cycle after reset always loads.
  always_comb begin
    tick           = (presc_q == PRESC_LAST);
    wrap           = tick && (sel_q == SEL_LAST);
    load           = wrap || load_pending_q;
    presc_d        = tick ? '0 : presc_q + 1'b1;
    sel_d          = tick ? (wrap ? 3'd0 : sel_q + 3'd1) : sel_q;
    load_pending_d = 1'b0;
    frame_start_d  = load;
    sh_data_d      = load ? bus.data_in  : sh_data_q;
    sh_dp_d        = load ? bus.dp_in    : sh_dp_q;
    sh_blank_d     = load ? bus.blank_in : sh_blank_q;
    sh_lz_d        = load ? bus.lz_blank : sh_lz_q;
  end

  // Outputs use next-state sel/prescaler/shadow so seg lines up with sel.
  always_comb begin
    lead_zero = '0;
    higher_ok = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lead_zero[k] = higher_ok && (sh_data_d[4*k +: 4] == 4'h0);
      higher_ok    = higher_ok && ((sh_data_d[4*k +: 4] == 4'h0) || sh_blank_d[k]);
    end
    nib   = sh_data_d[{sel_d, 2'b00} +: 4];
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if ((presc_d >= DEAD_LIM) && !sh_blank_d[sel_d]) begin
      dp_d = ~sh_dp_d[sel_d];
      if (!(sh_lz_d && (sel_d != 3'd0) && lead_zero[sel_d]))
        seg_d = hex7(nib);
    end
  end

  assign bus.sel         = sel_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: an 8-digit and a 5-digit instance share stimulus and
// are checked every cycle against a slot-count model, plus literal spot checks.
module tb_seg_scan_ctrl;

  localparam int R    = 4;
  localparam int DEAD = 1;
  localparam int DG [2] = '{8, 5};
  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  seg_scan_if ifa ();
  seg_scan_if ifb ();

  seg_scan_ctrl #(.REFRESH_DIV(R), .DEAD_CYCLES(DEAD), .DIGITS(8)) u_dut8 (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  seg_scan_ctrl #(.REFRESH_DIV(R), .DEAD_CYCLES(DEAD), .DIGITS(5)) u_dut5 (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  always #5 clk = ~clk;

  // Model: n = clock edges since reset released; everything follows from n.
  int          n [2];
  logic [31:0] sh_data [2];
  logic [7:0]  sh_dp [2];
  logic [7:0]  sh_blank [2];
  logic        sh_lz [2];
  bit          started = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        n[i] = 0;
        sh_data[i] = '0; sh_dp[i] = '0; sh_blank[i] = 8'hFF; sh_lz[i] = 1'b0;
        started = 1'b1;
      end else if (started) begin
        n[i] = n[i] + 1;
        if (n[i] == 1 || n[i] % (R * DG[i]) == 0) begin
          sh_data[i] = ifa.data_in; sh_dp[i] = ifa.dp_in;
          sh_blank[i] = ifa.blank_in; sh_lz[i] = ifa.lz_blank;
        end
      end
    end
  end

  function automatic bit is_lead_zero(input int i, input int s);
    if (s == 0) return 1'b0;
    if (sh_data[i][4*s +: 4] != 4'h0) return 1'b0;
    for (int j = s + 1; j < DG[i]; j++)
      if (sh_data[i][4*j +: 4] != 4'h0 && !sh_blank[i][j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_out(input int i, output logic [2:0] es, output logic [6:0] eg,
                           output logic ed, output logic ef);
    int p, s;
    es = 3'd0; eg = 7'h7F; ed = 1'b1; ef = 1'b0;
    if (n[i] != 0) begin
      p  = n[i] % R;
      s  = (n[i] / R) % DG[i];
      es = 3'(s);
      ef = (n[i] == 1) || (n[i] % (R * DG[i]) == 0);
      if (p >= DEAD && !sh_blank[i][s]) begin
        ed = ~sh_dp[i][s];
        if (!(sh_lz[i] && is_lead_zero(i, s))) eg = HEX[sh_data[i][4*s +: 4]];
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cmp_dut(input int i, input logic [2:0] s, input logic [6:0] g,
                         input logic d, input logic f);
    logic [2:0] es; logic [6:0] eg; logic ed, ef;
    model_out(i, es, eg, ed, ef);
    chk($sformatf("d%0d_sel n=%0d", DG[i], n[i]), 32'(s), 32'(es));
    chk($sformatf("d%0d_seg n=%0d", DG[i], n[i]), 32'(g), 32'(eg));
    chk($sformatf("d%0d_dp n=%0d", DG[i], n[i]), 32'(d), 32'(ed));
    chk($sformatf("d%0d_fs n=%0d", DG[i], n[i]), 32'(f), 32'(ef));
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp_dut(0, ifa.sel, ifa.seg, ifa.dp, ifa.frame_start);
      cmp_dut(1, ifb.sel, ifb.seg, ifb.dp, ifb.frame_start);
    end
  end

  task automatic set_in(input logic [31:0] d, input logic [7:0] dpv,
                        input logic [7:0] bl, input logic lz);
    ifa.data_in = d; ifa.dp_in = dpv; ifa.blank_in = bl; ifa.lz_blank = lz;
    ifb.data_in = d; ifb.dp_in = dpv; ifb.blank_in = bl; ifb.lz_blank = lz;
  endtask

  task automatic goto(input int target);
    bit hit = 1'b0;
    for (int k = 0; k < 400 && !hit; k++) begin
      @(negedge clk);
      if (n[0] == target) hit = 1'b1;
    end
    if (!hit) begin
      vectors++; miscompares++;
      $display("FAIL goto_timeout: got n=%0d expected n=%0d", n[0], target);
    end
  endtask

  initial begin
    reset = 1'b1;
    set_in(32'h76543210, 8'h01, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_sel", 32'(ifa.sel), 32'd0);
    chk("rst_seg", 32'(ifa.seg), 32'h7F);
    chk("rst_dp",  32'(ifa.dp), 32'd1);
    chk("rst_fs",  32'(ifa.frame_start), 32'd0);
    reset = 1'b0;

    goto(1);
    chk("first_fs", 32'(ifa.frame_start), 32'd1);
    chk("d0_seg",   32'(ifa.seg), 32'h40);
    chk("d0_dp",    32'(ifa.dp), 32'd0);
    goto(12); chk("d3_dead", 32'(ifa.seg), 32'h7F);
    goto(13); chk("d3_seg", 32'(ifa.seg), 32'h30); chk("d3_dp", 32'(ifa.dp), 32'd1);
    goto(32); chk("wrap_fs", 32'(ifa.frame_start), 32'd1); chk("wrap_sel", 32'(ifa.sel), 32'd0);

    goto(40); set_in(32'h00000000, 8'h01, 8'h00, 1'b0);
    goto(77); set_in(32'hFFFFFFFF, 8'h01, 8'h00, 1'b0);
    goto(86); chk("tear_d5", 32'(ifa.seg), 32'h40);
    goto(97); chk("newF_d0", 32'(ifa.seg), 32'h0E);

    goto(100); set_in(32'h00000A05, 8'h01, 8'h00, 1'b1);
    goto(127); chk("newF_d7", 32'(ifa.seg), 32'h0E);
    goto(129); chk("lz_d0", 32'(ifa.seg), 32'h12);
    goto(133); chk("lz_d1", 32'(ifa.seg), 32'h40);
    goto(137); chk("lz_d2", 32'(ifa.seg), 32'h08);
    goto(140); set_in(32'h00000000, 8'h01, 8'h00, 1'b1);
    goto(141); chk("lz_d3", 32'(ifa.seg), 32'h7F);
    goto(157); chk("lz_d7", 32'(ifa.seg), 32'h7F);
    goto(161); chk("lz0_d0", 32'(ifa.seg), 32'h40);
    goto(165); chk("lz0_d1", 32'(ifa.seg), 32'h7F);

    goto(170); set_in(32'h76543210, 8'hFF, 8'h80, 1'b0);
    goto(192); chk("bl_dead_dp", 32'(ifa.dp), 32'd1);
    goto(193); chk("bl_d0_dp", 32'(ifa.dp), 32'd0);
    goto(221); chk("bl_d7_seg", 32'(ifa.seg), 32'h7F); chk("bl_d7_dp", 32'(ifa.dp), 32'd1);

    goto(246);
    chk("pre_rst_sel", 32'(ifa.sel), 32'd5);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_sel", 32'(ifa.sel), 32'd0);
    chk("mid_rst_seg", 32'(ifa.seg), 32'h7F);
    chk("mid_rst_fs",  32'(ifa.frame_start), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_fs", 32'(ifa.frame_start), 32'd1);
    goto(16); chk("d5_sel4", 32'(ifb.sel), 32'd4);
    goto(20); chk("d5_wrap_sel", 32'(ifb.sel), 32'd0); chk("d5_wrap_fs", 32'(ifb.frame_start), 32'd1);
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
